// File: rtl/offnariscv_pkg.sv
// Shared ACE snoop definitions: channel field widths, CRRESP bit positions,
// ACSNOOP encodings and the snoop initiator state type.
package offnariscv_pkg;

  localparam int ACE_ACSNOOP_WIDTH = 4;
  localparam int ACE_ACPROT_WIDTH  = 3;
  localparam int ACE_CRRESP_WIDTH  = 5;

  localparam int CR_DATA_TRANSFER = 0;
  localparam int CR_ERROR         = 1;
  localparam int CR_PASS_DIRTY    = 2;
  localparam int CR_IS_SHARED     = 3;
  localparam int CR_WAS_UNIQUE    = 4;

  localparam logic [ACE_ACSNOOP_WIDTH-1:0] ACSNOOP_READ_ONCE              = 4'b0000;
  localparam logic [ACE_ACSNOOP_WIDTH-1:0] ACSNOOP_READ_SHARED            = 4'b0001;
  localparam logic [ACE_ACSNOOP_WIDTH-1:0] ACSNOOP_READ_CLEAN             = 4'b0010;
  localparam logic [ACE_ACSNOOP_WIDTH-1:0] ACSNOOP_READ_NOT_SHARED_DIRTY  = 4'b0011;
  localparam logic [ACE_ACSNOOP_WIDTH-1:0] ACSNOOP_READ_UNIQUE            = 4'b0111;
  localparam logic [ACE_ACSNOOP_WIDTH-1:0] ACSNOOP_CLEAN_SHARED           = 4'b1000;
  localparam logic [ACE_ACSNOOP_WIDTH-1:0] ACSNOOP_CLEAN_INVALID          = 4'b1001;
  localparam logic [ACE_ACSNOOP_WIDTH-1:0] ACSNOOP_MAKE_INVALID           = 4'b1101;

  typedef enum logic [1:0] {IDLE, AC, WAIT, RSP} ace_snoop_state_e;

endpackage

// File: rtl/ace_cd_collector.sv
// CD channel beat collector: counts beats into a line buffer and flags
// cdlast placement errors. Cleared when the consolidated result is taken.
module ace_cd_collector #(
  parameter int W          = 256,
  parameter int LINE_BEATS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    cdvalid_i,
  input  logic                    cdlast_i,
  input  logic [W-1:0]            cddata_i,
  output logic                    cdready_o,
  output logic [W*LINE_BEATS-1:0] line_o,
  output logic                    full_o,
  output logic                    any_o,
  output logic                    err_o
);
  localparam int CW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_BEATS - 1);

  logic [CW-1:0]                 cnt_q;
  logic                          full_q, err_q;
  logic [LINE_BEATS-1:0][W-1:0]  line_q;
  logic                          hs, at_last;

  assign cdready_o = en_i & ~full_q;
  assign hs        = cdready_o & cdvalid_i;
  assign at_last   = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
      line_q <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
      line_q <= '0;
    end else if (hs) begin
      line_q[cnt_q] <= cddata_i;
      cnt_q         <= at_last ? '0 : cnt_q + 1'b1;
      if (at_last) full_q <= 1'b1;
      // cdlast must appear exactly on the final slot of the line
      if (cdlast_i != at_last) err_q <= 1'b1;
    end
  end

  // full_o includes a beat completing the line this cycle so the parent can leave WAIT on it
  assign full_o = full_q | (hs & at_last);
  assign any_o  = full_q | (cnt_q != '0);
  assign err_o  = err_q;
  assign line_o = line_q;

endmodule

// File: rtl/ace_snoop_initiator.sv
// Drives one ACE snoop on AC, gathers CR/CD and returns one consolidated result.
// Optional watchdog on the response wait: define ACE_SNOOP_TIMEOUT_EN.
module ace_snoop_initiator
  import offnariscv_pkg::*;
#(
  parameter int ACE_XDATA_WIDTH  = 256,
  parameter int ACE_AXADDR_WIDTH = 32,
  parameter int LINE_BEATS       = 1,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ACE_AXADDR_WIDTH-1:0]           req_addr,
  input  logic [ACE_ACSNOOP_WIDTH-1:0]          req_snoop,
  input  logic [ACE_ACPROT_WIDTH-1:0]           req_prot,
  output logic                                  acvalid,
  input  logic                                  acready,
  output logic [ACE_AXADDR_WIDTH-1:0]           acaddr,
  output logic [ACE_ACSNOOP_WIDTH-1:0]          acsnoop,
  output logic [ACE_ACPROT_WIDTH-1:0]           acprot,
  input  logic                                  crvalid,
  output logic                                  crready,
  input  logic [ACE_CRRESP_WIDTH-1:0]           crresp,
  input  logic                                  cdvalid,
  output logic                                  cdready,
  input  logic [ACE_XDATA_WIDTH-1:0]            cddata,
  input  logic                                  cdlast,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [ACE_CRRESP_WIDTH-1:0]           rsp_crresp,
  output logic [ACE_XDATA_WIDTH*LINE_BEATS-1:0] rsp_data,
  output logic                                  rsp_has_data,
  output logic                                  rsp_err
);
  ace_snoop_state_e                 state_q, state_d;
  logic                             rdy_q;
  logic [ACE_AXADDR_WIDTH-1:0]      addr_q;
  logic [ACE_ACSNOOP_WIDTH-1:0]     snoop_q;
  logic [ACE_ACPROT_WIDTH-1:0]      prot_q;
  logic [ACE_CRRESP_WIDTH-1:0]      crresp_q, cr_eff;
  logic                             cr_done_q;
  logic                             req_hs, cr_hs, rsp_hs, in_wait, done, to_hit, timed_out;
  logic                             cd_full, cd_any, cd_err;
  logic [ACE_XDATA_WIDTH*LINE_BEATS-1:0] cd_line;

  // rdy_q keeps req_ready low while reset is asserted even though IDLE is the reset state
  assign req_ready = rdy_q & (state_q == IDLE);
  assign acvalid   = (state_q == AC);
  assign acaddr    = addr_q;
  assign acsnoop   = snoop_q;
  assign acprot    = prot_q;
  assign in_wait   = (state_q == WAIT);
  assign crready   = in_wait & ~cr_done_q;
  assign rsp_valid = (state_q == RSP);

  assign req_hs = req_valid & req_ready;
  assign cr_hs  = crvalid & crready;
  assign rsp_hs = rsp_valid & rsp_ready;
  assign cr_eff = cr_hs ? crresp : crresp_q;
  assign done   = (cr_done_q | cr_hs) & (~cr_eff[CR_DATA_TRANSFER] | cd_full);

  ace_cd_collector #(.W(ACE_XDATA_WIDTH), .LINE_BEATS(LINE_BEATS)) u_cd (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (rsp_hs),
    .en_i      (in_wait),
    .cdvalid_i (cdvalid),
    .cdlast_i  (cdlast),
    .cddata_i  (cddata),
    .cdready_o (cdready),
    .line_o    (cd_line),
    .full_o    (cd_full),
    .any_o     (cd_any),
    .err_o     (cd_err)
  );

`ifdef ACE_SNOOP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] to_cnt_q;
  logic          to_q;

  assign to_hit    = in_wait & (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign timed_out = to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (acvalid & acready) to_cnt_q <= '0;
      else if (in_wait)      to_cnt_q <= to_cnt_q + 1'b1;
      if (to_hit & ~done)    to_q <= 1'b1;
      else if (rsp_hs)       to_q <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign to_hit    = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_hs)       state_d = AC;
      AC:   if (acready)      state_d = WAIT;
      WAIT: if (done | to_hit) state_d = RSP;
      RSP:  if (rsp_ready)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
      crresp_q  <= '0;
      cr_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (req_hs) begin
        addr_q  <= req_addr;
        snoop_q <= req_snoop;
        prot_q  <= req_prot;
      end
      if (rsp_hs) begin
        crresp_q  <= '0;
        cr_done_q <= 1'b0;
      end else if (cr_hs) begin
        crresp_q  <= crresp;
        cr_done_q <= 1'b1;
      end
    end
  end

  assign rsp_crresp   = crresp_q;
  assign rsp_has_data = rsp_valid & crresp_q[CR_DATA_TRANSFER] & cd_full & ~timed_out;
  assign rsp_data     = rsp_has_data ? cd_line : '0;
  // data with DataTransfer=0 is a protocol error even though it is discarded
  assign rsp_err      = rsp_valid & (cd_err | crresp_q[CR_ERROR] |
                                     (cd_any & ~crresp_q[CR_DATA_TRANSFER]) | timed_out);

endmodule
